// File: rtl/mem_fifo_sched.sv
// Round-robin write scheduler and read pump for memory_core in FIFO mode, with a 2-entry output skid.
// Optional SVA checks compile in when MEM_FIFO_SCHED_ASSERT_EN is defined.
module mem_fifo_sched #(
  parameter int NREQ    = 2,
  parameter int DATA_W  = 16,
  parameter int DEPTH_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic [DEPTH_W-1:0]           depth,
  input  logic                         start,
  input  logic                         flush_req,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0][DATA_W-1:0]  req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic                         core_wen,
  output logic [DATA_W-1:0]            core_data,
  output logic                         core_ren,
  input  logic                         core_valid,
  input  logic [DATA_W-1:0]            core_dout,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         out_ready,
  output logic [DEPTH_W:0]             occ,
  output logic                         full,
  output logic                         empty,
  output logic [1:0]                   state
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = DEPTH_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                   st_q, st_d;
  logic [DEPTH_W-1:0]       depth_q;
  logic [CW-1:0]            occ_q, avail_q, occ_nxt, avail_nxt;
  logic [GW-1:0]            last_q, gidx, sel;
  logic                     wen_q, ren_q, ren_d;
  logic [DATA_W-1:0]        data_q;
  logic [1:0][DATA_W-1:0]   skid_mem;
  logic [1:0]               skid_cnt, skid_nxt, wr2;
  logic [NREQ-1:0]          gnt;
  logic                     hs, push, pop;

  // Scan from farthest to nearest so the nearest valid index after last_q wins.
  always_comb begin
    gnt  = '0;
    gidx = last_q;
    sel  = '0;
    if (clk_en && st_q == RUN && occ_q < {1'b0, depth_q}) begin
      for (int k = NREQ; k >= 1; k--) begin
        sel = GW'((int'(last_q) + k) % NREQ);
        if (req_valid[sel]) begin
          gnt      = '0;
          gnt[sel] = 1'b1;
          gidx     = sel;
        end
      end
    end
  end

  assign hs   = |gnt;
  assign push = clk_en & core_valid;
  assign pop  = clk_en & out_valid & out_ready;

  // Read credit counts the skid after this cycle's push/pop plus the read already in the core.
  always_comb begin
    skid_nxt  = skid_cnt + 2'(push) - 2'(pop);
    wr2       = skid_cnt - 2'(pop);
    avail_nxt = avail_q + CW'(wen_q) - CW'(ren_q);
    occ_nxt   = occ_q + CW'(hs) - CW'(ren_q);
    ren_d     = (avail_nxt != '0) && ((3'(skid_nxt) + 3'(ren_q)) < 3'd2);
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (start && depth != '0) st_d = RUN;
      RUN:     if (flush_req) st_d = DRAIN;
      DRAIN:   if (occ_q == '0 && avail_q == '0 && skid_cnt == 2'd0 && !wen_q) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= IDLE;
      depth_q  <= '0;
      occ_q    <= '0;
      avail_q  <= '0;
      last_q   <= GW'(NREQ - 1);
      wen_q    <= 1'b0;
      data_q   <= '0;
      ren_q    <= 1'b0;
      skid_mem <= '0;
      skid_cnt <= 2'd0;
    end else if (clk_en) begin
      st_q <= st_d;
      if (st_q == IDLE && st_d == RUN) depth_q <= depth;
      occ_q   <= occ_nxt;
      avail_q <= avail_nxt;
      wen_q   <= hs;
      ren_q   <= ren_d;
      if (hs) begin
        last_q <= gidx;
        data_q <= req_data[gidx];
      end
      // Later write to the same slot overrides the shift when popping and pushing together.
      if (pop)  skid_mem[0] <= skid_mem[1];
      if (push) skid_mem[wr2[0]] <= core_dout;
      skid_cnt <= skid_nxt;
    end
  end

  assign req_ready = gnt;
  assign core_wen  = wen_q & clk_en;
  assign core_data = data_q;
  assign core_ren  = ren_q & clk_en;
  assign out_valid = (skid_cnt != 2'd0);
  assign out_data  = skid_mem[0];
  assign occ       = occ_q;
  assign full      = (depth_q != '0) && (occ_q >= {1'b0, depth_q});
  assign empty     = (occ_q == '0) && (skid_cnt == 2'd0);
  assign state     = st_q;

`ifdef MEM_FIFO_SCHED_ASSERT_EN
  logic [DEPTH_W+2:0] wait_q;
  always_ff @(posedge clk) begin
    if (reset || !out_ready || pop || empty) wait_q <= '0;
    else if (clk_en) wait_q <= wait_q + (DEPTH_W+3)'(1);
  end

  a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
  a_full:   assert property (@(posedge clk) disable iff (reset) full |-> req_ready == '0);
  a_ren:    assert property (@(posedge clk) disable iff (reset) core_ren |-> avail_q != '0);
  a_skid:   assert property (@(posedge clk) disable iff (reset)
                             skid_cnt <= 2'd2 && !(push && !pop && skid_cnt == 2'd2));
  a_hold:   assert property (@(posedge clk) disable iff (reset)
                             out_valid && !out_ready |=> $stable(out_data));
  a_cvld:   assert property (@(posedge clk) disable iff (reset)
                             clk_en && $past(clk_en) |-> core_valid == $past(core_ren));
  a_live:   assert property (@(posedge clk) disable iff (reset)
                             wait_q <= (DEPTH_W+3)'({depth_q, 2'b00}) + (DEPTH_W+3)'(4));
`endif
endmodule

// File: tb/tb_mem_fifo_sched.sv
// Randomized and directed bench for mem_fifo_sched; memory_core modeled as a queue with 1-cycle read latency.
module tb_mem_fifo_sched;
  localparam int NREQ = 2;
  localparam int DW   = 16;
  localparam int DPW  = 16;

  logic                      clk = 1'b0;
  logic                      reset, clk_en, start, flush_req, out_ready;
  logic [DPW-1:0]            depth;
  logic [NREQ-1:0]           req_valid, req_ready;
  logic [NREQ-1:0][DW-1:0]   req_data;
  logic                      core_wen, core_ren, core_valid, out_valid, full, empty;
  logic [DW-1:0]             core_data, core_dout, out_data;
  logic [DPW:0]              occ;
  logic [1:0]                state;

  always #5 clk = ~clk;

  mem_fifo_sched #(.NREQ(NREQ), .DATA_W(DW), .DEPTH_W(DPW)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .depth(depth), .start(start),
    .flush_req(flush_req), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .core_wen(core_wen), .core_data(core_data),
    .core_ren(core_ren), .core_valid(core_valid), .core_dout(core_dout),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occ(occ), .full(full), .empty(empty), .state(state)
  );

  // memory_core stand-in: gated by clk_en, read data appears one cycle after ren
  logic [DW-1:0] cq[$];
  always @(posedge clk) begin
    if (reset) begin
      core_valid <= 1'b0;
      core_dout  <= '0;
      cq.delete();
    end else if (clk_en) begin
      core_valid <= core_ren;
      if (core_ren) core_dout <= (cq.size() != 0) ? cq.pop_front() : 16'hdead;
      if (core_wen) cq.push_back(core_data);
    end
  end

  int total = 0, bad = 0, cyc = 0;
  int m_state, m_depth, m_occ, m_last, first_hs, first_ov, last_hs;
  logic [DW-1:0] sb[$];
  logic          prev_hold;
  logic [DW-1:0] prev_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // nearest valid producer going forward from last, wrapping around
  function automatic logic [NREQ-1:0] exp_gnt(logic [NREQ-1:0] v, int last);
    int best = NREQ + 1, bi = -1, d;
    logic [NREQ-1:0] g = '0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - last - 1 + 2 * NREQ) % NREQ;
      if (v[i] && d < best) begin best = d; bi = i; end
    end
    for (int i = 0; i < NREQ; i++) if (i == bi) g[i] = 1'b1;
    return g;
  endfunction

  task automatic cycle();
    logic [NREQ-1:0] ge, hv;
    logic pop, rd;
    #1;
    if (m_state == 2 && state == 2'd0) begin
      chk("drain_occ", 64'(m_occ), 64'(0));
      chk("drain_left", 64'(sb.size() <= 1), 64'(1));
      m_state = 0;
    end
    chk("state", 64'(state), 64'(m_state));
    ge = (m_state == 1 && clk_en && m_occ < m_depth) ? exp_gnt(req_valid, m_last) : '0;
    chk("gnt", 64'(req_ready), 64'(ge));
    chk("occ", 64'(occ), 64'(m_occ));
    chk("full", 64'(full), 64'(m_depth != 0 && m_occ >= m_depth));
    if (prev_hold) begin
      chk("hold_v", 64'(out_valid), 64'(1));
      chk("hold_d", 64'(out_data), 64'(prev_data));
    end
    if (!clk_en) begin
      chk("gate_wen", 64'(core_wen), 64'(0));
      chk("gate_ren", 64'(core_ren), 64'(0));
    end
    if (out_valid && first_ov < 0) first_ov = cyc;
    pop = out_valid && out_ready && clk_en;
    if (pop) begin
      if (sb.size() == 0) chk("extra_word", 64'(out_data), 64'hffff_ffff);
      else chk("data", 64'(out_data), 64'(sb.pop_front()));
    end
    prev_hold = out_valid && !pop;
    prev_data = out_data;
    rd = core_ren;
    hv = req_valid & req_ready;
    last_hs = int'(hv != '0);
    for (int i = 0; i < NREQ; i++)
      if (hv[i]) begin sb.push_back(req_data[i]); m_last = i; end
    if (hv != '0 && first_hs < 0) first_hs = cyc;
    m_occ = m_occ + last_hs - int'(rd);
    if (clk_en) begin
      if (m_state == 0 && start && depth != '0) begin m_state = 1; m_depth = int'(depth); end
      else if (m_state == 1 && flush_req) m_state = 2;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; clk_en = 1'b1; start = 1'b0; flush_req = 1'b0;
    out_ready = 1'b0; req_valid = '1; depth = '0;
    @(negedge clk);
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_wen", 64'(core_wen), 64'(0));
    chk("rst_cdata", 64'(core_data), 64'(0));
    chk("rst_ren", 64'(core_ren), 64'(0));
    chk("rst_ovalid", 64'(out_valid), 64'(0));
    chk("rst_odata", 64'(out_data), 64'(0));
    chk("rst_occ", 64'(occ), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    reset = 1'b0; req_valid = '0;
    m_state = 0; m_depth = 0; m_occ = 0; m_last = NREQ - 1;
    sb.delete(); prev_hold = 1'b0; first_hs = -1; first_ov = -1;
  endtask

  task automatic go(input int d);
    depth = DPW'(d); start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic run_push(input int prod, input int ncyc, input logic [DW-1:0] base, output int n);
    n = 0;
    for (int c = 0; c < ncyc; c++) begin
      req_valid = '0;
      for (int i = 0; i < NREQ; i++)
        if (i == prod) begin req_valid[i] = 1'b1; req_data[i] = base + DW'(n); end
      cycle();
      n += last_hs;
    end
    req_valid = '0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    req_valid = '0; flush_req = 1'b1;
    cycle();
    flush_req = 1'b0; out_ready = 1'b1; req_valid = '1;
    while (m_state != 0 && k < 200) begin cycle(); k++; end
    if (m_state != 0) chk({tag, "_timeout"}, 64'(m_state), 64'(0));
    repeat (4) cycle();
    chk({tag, "_left"}, 64'(sb.size()), 64'(0));
    chk({tag, "_empty"}, 64'(empty), 64'(1));
    req_valid = '0;
  endtask

  initial begin
    int n, o;
    req_data = '0;
    do_reset();

    // depth 0 start is ignored; depth 4 holds 4 in the core plus 2 in the skid
    go(0);
    go(4);
    run_push(0, 12, 16'h0011, n);
    chk("t1_count", 64'(n), 64'(6));
    chk("t1_full", 64'(full), 64'(1));
    chk("t1_occ", 64'(occ), 64'(4));
    req_valid = 2'b01; #1;
    chk("t1_blocked", 64'(req_ready), 64'(0));
    req_valid = '0;
    drain("t1");

    // both producers always valid: alternating grants, first-word latency 4
    do_reset();
    go(8);
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      req_valid = '1;
      for (int i = 0; i < NREQ; i++) req_data[i] = DW'($urandom);
      cycle();
    end
    chk("t2_latency", 64'(first_ov - first_hs), 64'(4));
    drain("t2");

    // flush with 5 stored, then a new start with depth 2
    do_reset();
    go(8);
    run_push(1, 5, 16'h0400, n);
    chk("t4_count", 64'(n), 64'(5));
    drain("t4");
    go(2);
    out_ready = 1'b0;
    run_push(0, 10, 16'h0700, n);
    chk("t4_cap", 64'(n), 64'(4));
    drain("t4b");

    // clock-enable freeze with data presented
    do_reset();
    go(8);
    run_push(1, 3, 16'h0500, n);
    repeat (3) cycle();
    chk("t5_ovalid", 64'(out_valid), 64'(1));
    o = int'(occ);
    clk_en = 1'b0; out_ready = 1'b1; req_valid = '1;
    repeat (3) cycle();
    chk("t5_occ", 64'(occ), 64'(o));
    clk_en = 1'b1; req_valid = '0;
    drain("t5");

    // reset with entries in flight
    do_reset();
    go(8);
    run_push(0, 3, 16'h0600, n);
    do_reset();

    // randomized traffic
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 1) do_reset();
      go(int'($urandom_range(1, 8)));
      for (int c = 0; c < 150; c++) begin
        req_valid = NREQ'($urandom);
        for (int i = 0; i < NREQ; i++) req_data[i] = DW'($urandom);
        out_ready = ($urandom % 10) < 7;
        clk_en    = ($urandom % 10) != 0;
        cycle();
      end
      clk_en = 1'b1;
      drain("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
